// File: rtl/onehot_to_bin_tracker_pkg.sv
// Shared interconnect definitions: default widths, the tracker entry layout
// and the binary-to-one-hot constants used alongside it.
package onehot_to_bin_tracker_pkg;

    localparam int DEF_ONEHOT_WIDTH = 4;
    localparam int DEF_BIN_WIDTH    = $clog2(DEF_ONEHOT_WIDTH);
    localparam int DEF_DEPTH        = 4;

    // Binary-to-one-hot constants for the default select width.
    localparam logic [DEF_ONEHOT_WIDTH-1:0] ONEHOT_SEL0 = 4'b0001;
    localparam logic [DEF_ONEHOT_WIDTH-1:0] ONEHOT_SEL1 = 4'b0010;
    localparam logic [DEF_ONEHOT_WIDTH-1:0] ONEHOT_SEL2 = 4'b0100;
    localparam logic [DEF_ONEHOT_WIDTH-1:0] ONEHOT_SEL3 = 4'b1000;

    typedef struct packed {
        logic [DEF_BIN_WIDTH-1:0] bin;
        logic                     err;
    } entry_t;

    function automatic logic [DEF_ONEHOT_WIDTH-1:0] bin_to_onehot(
        input logic [DEF_BIN_WIDTH-1:0] bin
    );
        logic [DEF_ONEHOT_WIDTH-1:0] oh;
        oh = '0;
        oh[bin] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/onehot_to_bin_tracker_onehot_to_bin.sv
// Combinational one-hot encoder: index of the lowest set bit, plus a flag
// when the input is not exactly one-hot (all-zero encodes 0 with err set).
module onehot_to_bin
    import onehot_to_bin_tracker_pkg::*;
#(
    parameter int ONEHOT_WIDTH = DEF_ONEHOT_WIDTH,
    parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
    input  logic [ONEHOT_WIDTH-1:0] onehot,
    output logic [BIN_WIDTH-1:0]    bin,
    output logic                    err
);

    logic any_set;
    logic multi_set;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        bin = '0;
        for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                bin = BIN_WIDTH'(i);
            end
        end
    end

    assign any_set   = |onehot;
    assign multi_set = |(onehot & (onehot - ONEHOT_WIDTH'(1)));
    assign err       = !any_set || multi_set;

endmodule

// File: rtl/onehot_to_bin_tracker.sv
// Small FIFO of encoded one-hot requests; each entry holds {bin, err} and is
// returned in push order with one cycle of latency (no bypass).
module onehot_to_bin_tracker
    import onehot_to_bin_tracker_pkg::*;
#(
    parameter int ONEHOT_WIDTH = DEF_ONEHOT_WIDTH,
    parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH),
    parameter int DEPTH        = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [ONEHOT_WIDTH-1:0]    req_onehot_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [BIN_WIDTH-1:0]       resp_bin_o,
    output logic                       resp_err_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; ready depends only on registered count, never on the peer.
    logic [BIN_WIDTH-1:0] enc_bin;
    logic                 enc_err;
    logic [BIN_WIDTH:0]   mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 push;
    logic                 pop;

    onehot_to_bin #(
        .ONEHOT_WIDTH (ONEHOT_WIDTH),
        .BIN_WIDTH    (BIN_WIDTH)
    ) u_enc (
        .onehot (req_onehot_i),
        .bin    (enc_bin),
        .err    (enc_err)
    );

    assign req_ready_o  = (count != CNT_W'(DEPTH));
    assign resp_valid_o = (count != '0);
    assign push         = req_valid_i && req_ready_o;
    assign pop          = resp_valid_o && resp_ready_i;

    // Storage is unreset; outputs are masked while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {enc_bin, enc_err};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign resp_bin_o = resp_valid_o ? mem[rd_ptr][BIN_WIDTH:1] : '0;
    assign resp_err_o = resp_valid_o ? mem[rd_ptr][0] : 1'b0;
    assign count_o    = count;

endmodule

// File: doc/onehot_to_bin_tracker.md
ONEHOT_TO_BIN_TRACKER -- requirements
Module: onehot_to_bin_tracker

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 Parameter ONEHOT_WIDTH, default 4: width of the one-hot select vector, ≥2.
REQ-003 Parameter BIN_WIDTH, default $clog2(ONEHOT_WIDTH): width of the encoded index.
REQ-004 Parameter DEPTH, default 4: number of outstanding entries, a power of two ≥2.
REQ-005 Port clk, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port req_valid_i, input, 1: a one-hot request select is presented.
REQ-008 Port req_ready_o, output, 1: the tracker can accept an entry.
REQ-009 Port req_onehot_i, input, ONEHOT_WIDTH: one-hot bank/target select of the request.
REQ-010 Port resp_valid_o, output, 1: the head entry is available.
REQ-011 Port resp_ready_i, input, 1: the consumer takes the head entry.
REQ-012 Port resp_bin_o, output, BIN_WIDTH: encoded index of the head entry.
REQ-013 Port resp_err_o, output, 1: the head entry was not exactly one-hot.
REQ-014 Port count_o, output, $clog2(DEPTH)+1: occupancy.

Function
REQ-015 Encoding SHALL be: index of the lowest set bit of req_onehot_i; all-zero input SHALL encode 0.
REQ-016 The error flag SHALL be 1 when zero bits or more than one bit of req_onehot_i are set, else 0.
REQ-017 A push SHALL occur on a clock edge where req_valid_i=1 and req_ready_o=1; it stores {bin, err} at the write pointer.
REQ-018 A pop SHALL occur on a clock edge where resp_valid_o=1 and resp_ready_i=1; it advances the read pointer.
REQ-019 req_ready_o SHALL equal (count_o != DEPTH); a pop in the same cycle SHALL NOT make a full tracker ready.
REQ-020 resp_valid_o SHALL equal (count_o != 0); there SHALL be no bypass, so a push into an empty tracker is visible from the next cycle (latency 1).
REQ-021 resp_bin_o and resp_err_o SHALL show the head entry whenever resp_valid_o=1, held stable until popped.
REQ-022 A simultaneous push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0; count SHALL never exceed DEPTH or underflow below 0.
REQ-024 req_onehot_i with req_valid_i=0 SHALL have no effect.
REQ-025 Order SHALL be strictly FIFO: responses are returned in push order.

Reset
REQ-026 On rst_n=0, regardless of clock, the tracker SHALL clear pointers and count, discarding all entries, including mid-operation.
REQ-027 During and after reset, until the next push: req_ready_o=1, resp_valid_o=0, resp_bin_o=0, resp_err_o=0, count_o=0.
REQ-028 Storage contents need no reset, but outputs SHALL be forced to 0 while empty.

Structure
REQ-029 The default widths and the entry struct {bin, err} SHALL be declared in the shared interconnect package, next to the binary-to-one-hot constants.
REQ-030 The combinational encoder (REQ-015/016) SHALL be a separate sub-module, onehot_to_bin, reused by the tracker.
REQ-031 There SHALL be no latches and no combinational path from resp_ready_i to req_ready_o.

Verification
REQ-032 Reset, then push 4'b0100 -> next cycle resp_valid_o=1, resp_bin_o=2, resp_err_o=0, count_o=1.
REQ-033 Push 0001, 0010, 1000, 0100 with resp_ready_i=0 -> req_ready_o=0, count_o=4; drain -> 0, 1, 3, 2 in order.
REQ-034 Push 4'b0000 and 4'b0110 -> resp_bin_o=0/err=1, then resp_bin_o=1/err=1.
REQ-035 At count_o=2, push and pop for 10 cycles -> count_o stays 2, pointers wrap, FIFO order holds.
REQ-036 Full tracker, assert resp_ready_i and req_valid_i together -> pop only, count_o=3, req_ready_o=1 next cycle.
REQ-037 Pulse rst_n low mid-burst with count_o=3 -> immediately resp_valid_o=0, count_o=0, req_ready_o=1.
